// File: rtl/ad9866_pkg.sv
// rtl/ad9866_pkg.sv - shared types, command codes and init table for the AD9866 SPI sequencer
package ad9866_pkg;

   // 16-bit AD9866 SPI write frame, sent MSB first
   typedef struct packed {
      logic       rw;     // 0 = write
      logic [1:0] len;    // 00 = one data byte
      logic [4:0] addr;
      logic [7:0] data;
   } spi_frame_t;

   typedef enum logic [2:0] {INIT, IDLE, LOAD, SHIFT, HOLD, GAP} state_t;

   localparam logic [5:0] CMD_GAIN   = 6'h0a;
   localparam logic [5:0] CMD_SPIWR  = 6'h3b;
   localparam logic [4:0] REG_RXGAIN = 5'h09;

   // Init table sized for the largest legal INIT_LEN; the top plays entries 0..INIT_LEN-1.
   // Each entry is {addr[4:0], data[7:0]}.
   localparam int INIT_MAX = 32;
   localparam logic [12:0] INIT_TABLE [INIT_MAX] = '{
      0: {5'h01, 8'h20},  1: {5'h02, 8'hC3},  2: {5'h03, 8'h00},  3: {5'h04, 8'h36},
      4: {5'h05, 8'h01},  5: {5'h06, 8'h0F},  6: {5'h07, 8'h00},  7: {5'h08, 8'h41},
      8: {5'h0A, 8'h00},  9: {5'h0B, 8'h00}, 10: {5'h0C, 8'h20}, 11: {5'h0D, 8'h00},
      default: 13'h0000
   };

   // RX gain register byte from the command word: bit 6 selects the direct 6-bit code,
   // otherwise bit 5 selects the inverted code, otherwise the upper half of the range.
   function automatic logic [7:0] rx_gain_byte(input logic [6:0] d);
      logic [5:0] g;
      if (d[6])      g = d[5:0];
      else if (d[5]) g = ~d[5:0];
      else           g = {1'b1, d[4:0]};
      return {2'b01, g};
   endfunction

   function automatic spi_frame_t mk_frame(input logic [4:0] addr, input logic [7:0] data);
      spi_frame_t f;
      f.rw   = 1'b0;
      f.len  = 2'b00;
      f.addr = addr;
      f.data = data;
      return f;
   endfunction

endpackage

// File: rtl/ad9866_spi_shift.sv
// rtl/ad9866_spi_shift.sv - 16-bit 3-wire SPI shifter with CLK_DIV-based SCLK generation
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   start_i        load frame_i, drop sen_n, present bit 15 on sdio
//   frame_i        16-bit frame, MSB first
//   stop_i         release sen_n (end of the hold phase)
//   sclk_o         SPI clock, idle low; CLK_DIV cycles low then CLK_DIV cycles high per bit
//   sen_n_o        SPI enable, active low
//   sdio_o         SPI data, changes together with sclk falling
//   shift_done_o   high in the last cycle of bit 0's high phase
module ad9866_spi_shift #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [15:0] frame_i,
   input  logic        stop_i,
   output logic        sclk_o,
   output logic        sen_n_o,
   output logic        sdio_o,
   output logic        shift_done_o
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   logic [14:0] sh_q;     // bits still to be sent after the one on sdio
   logic [3:0]  bit_q;    // index of the bit currently on sdio
   logic [7:0]  div_q;
   logic        sclk_q, sen_n_q, sdio_q, act_q;
   logic        phase_end;

   assign phase_end    = (div_q == DIV_LAST);
   assign shift_done_o = act_q & sclk_q & phase_end & (bit_q == 4'd0);
   assign sclk_o       = sclk_q;
   assign sen_n_o      = sen_n_q;
   assign sdio_o       = sdio_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q    <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         sclk_q  <= 1'b0;
         sen_n_q <= 1'b1;
         sdio_q  <= 1'b0;
         act_q   <= 1'b0;
      end else begin
         if (start_i) begin
            sh_q    <= frame_i[14:0];
            sdio_q  <= frame_i[15];
            sen_n_q <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= 4'd15;
            act_q   <= 1'b1;
         end else if (act_q) begin
            if (phase_end) begin
               div_q <= '0;
               if (!sclk_q) begin
                  sclk_q <= 1'b1;
               end else begin
                  // falling edge: next bit goes out together with sclk dropping
                  sclk_q <= 1'b0;
                  if (bit_q == 4'd0) begin
                     act_q <= 1'b0;
                  end else begin
                     bit_q  <= bit_q - 4'd1;
                     sdio_q <= sh_q[14];
                     sh_q   <= {sh_q[13:0], 1'b0};
                  end
               end
            end else begin
               div_q <= div_q + 8'd1;
            end
         end
         if (stop_i) begin
            sen_n_q <= 1'b1;
            sdio_q  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ad9866_spi_ctrl.sv
// rtl/ad9866_spi_ctrl.sv - AD9866 SPI sequencer: init table playback, then gain/generic write arbitration
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   cmd_addr     command slave address (0x0a gain write, 0x3b generic write)
//   cmd_data     command slave data
//   cmd_rqst     single-cycle command strobe
//   cmd_ack      pulse one cycle after an accepted request
//   sclk/sen_n/sdio  3-wire SPI port
//   busy         frame in flight or a slot pending
//   init_done    sticky, set after the last init frame
//   ovf          sticky, set when a generic write finds its slot full
module ad9866_spi_ctrl #(
   parameter int CLK_DIV  = 4,
   parameter int INIT_LEN = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  cmd_addr,
   input  logic [31:0] cmd_data,
   input  logic        cmd_rqst,
   output logic        cmd_ack,
   output logic        sclk,
   output logic        sen_n,
   output logic        sdio,
   output logic        busy,
   output logic        init_done,
   output logic        ovf
);

   import ad9866_pkg::*;

   localparam logic [8:0] HOLD_LAST = 9'(CLK_DIV - 1);
   localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);
   localparam logic [4:0] IDX_LAST  = 5'(INIT_LEN - 1);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [8:0]  cnt_q, cnt_d;
   logic        init_done_q, init_done_d;

   logic        gain_full_q, gen_full_q, ovf_q, ack_q;
   logic [7:0]  gain_q;
   logic [12:0] gen_q;

   logic        start, stop, take_gain, take_gen, shift_done;
   logic        req_gain, req_gen, gen_free;
   spi_frame_t  frame;
   logic [12:0] init_entry;
   logic [18:0] unused_cmd_bits;

   assign unused_cmd_bits = cmd_data[31:13];
   assign init_entry      = INIT_TABLE[idx_q];

   assign req_gain = cmd_rqst & (cmd_addr == CMD_GAIN);
   assign req_gen  = cmd_rqst & (cmd_addr == CMD_SPIWR);
   // a generic slot being loaded this cycle can take a new request on the same edge
   assign gen_free = ~gen_full_q | take_gen;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      start       = 1'b0;
      stop        = 1'b0;
      take_gain   = 1'b0;
      take_gen    = 1'b0;
      frame       = mk_frame(init_entry[12:8], init_entry[7:0]);
      case (state_q)
         INIT: begin
            start   = 1'b1;
            state_d = SHIFT;
         end
         IDLE: begin
            if (gain_full_q || gen_full_q) state_d = LOAD;
         end
         LOAD: begin
            start   = 1'b1;
            state_d = SHIFT;
            if (gain_full_q) begin
               take_gain = 1'b1;
               frame     = mk_frame(REG_RXGAIN, gain_q);
            end else begin
               take_gen  = gen_full_q;
               frame     = mk_frame(gen_q[12:8], gen_q[7:0]);
            end
         end
         SHIFT: begin
            if (shift_done) begin
               cnt_d   = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               stop    = 1'b1;
               cnt_d   = '0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (init_done_q) begin
                  state_d = IDLE;
               end else if (idx_q == IDX_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = IDLE;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = INIT;
               end
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         idx_q       <= '0;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // Request slots: gain coalesces, generic holds one entry and flags overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gain_full_q <= 1'b0;
         gain_q      <= '0;
         gen_full_q  <= 1'b0;
         gen_q       <= '0;
         ovf_q       <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         ack_q <= req_gain | (req_gen & gen_free);
         if (req_gain) begin
            gain_full_q <= 1'b1;
            gain_q      <= rx_gain_byte(cmd_data[6:0]);
         end else if (take_gain) begin
            gain_full_q <= 1'b0;
         end
         if (req_gen && gen_free) begin
            gen_full_q <= 1'b1;
            gen_q      <= cmd_data[12:0];
         end else if (take_gen) begin
            gen_full_q <= 1'b0;
         end
         if (req_gen && !gen_free) ovf_q <= 1'b1;
      end
   end

   ad9866_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start),
      .frame_i      (frame),
      .stop_i       (stop),
      .sclk_o       (sclk),
      .sen_n_o      (sen_n),
      .sdio_o       (sdio),
      .shift_done_o (shift_done)
   );

   assign cmd_ack   = ack_q;
   assign init_done = init_done_q;
   assign ovf       = ovf_q;
   assign busy      = (state_q != IDLE) | gain_full_q | gen_full_q;

endmodule

// File: doc/ad9866_spi_ctrl.md
Name: ad9866_spi_ctrl

Overview:
- SPI configuration sequencer for the AD9866 codec.
- After reset, plays a fixed init table of register writes.
- Then arbitrates two requesters from the command slave bus onto the single 3-wire SPI port: RX gain writes (cmd 0x0a) and generic register writes (cmd 0x3b).
- Sits beside the ad9866 datapath block on the same clock and command bus.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- INIT_LEN, 12: number of entries in the init table; legal range 1..32.

Ports:
- clk  in  1  system clock (AD9866 clock domain)
- rst_n  in  1  reset; asynchronous, active-low
- cmd_addr  in  6  command slave address
- cmd_data  in  32  command slave data
- cmd_rqst  in  1  single-cycle command strobe
- cmd_ack  out  1  one-cycle pulse when the command is accepted into a slot
- sclk  out  1  SPI clock, idle low
- sen_n  out  1  SPI enable, active-low
- sdio  out  1  SPI data, MSB first
- busy  out  1  high while a frame is in flight or any slot is pending
- init_done  out  1  sticky high after the last init entry completes
- ovf  out  1  sticky high when a generic write is dropped; cleared by reset only

Behaviour:
- Reset values: sclk=0, sen_n=1, sdio=0, cmd_ack=0, busy=1, init_done=0, ovf=0. All slots empty; FSM in INIT.
- Frame format, 16 bits: bit15=0 (write), bits14:13=00 (one byte), bits12:8 = register address, bits7:0 = data.
- Generic slot (cmd 0x3b): addr=cmd_data[12:8], data=cmd_data[7:0].
- Gain slot (cmd 0x0a): addr=0x09, data={2'b01, g}, where g = cmd_data[6] ? cmd_data[5:0] : (cmd_data[5] ? ~cmd_data[5:0] : {1'b1, cmd_data[4:0]}).
- Slot capture, registered on the cycle after cmd_rqst:
  - 0x0a: always accepted. Overwrites any pending gain value (coalescing, never overflows). cmd_ack=1 next cycle.
  - 0x3b with generic slot empty: accepted, cmd_ack=1 next cycle.
  - 0x3b with generic slot full: dropped, cmd_ack=0, ovf<=1.
  - Any other cmd_addr: ignored, no ack.
  - Slots accept requests during INIT.
- FSM states:
  - INIT: load init entry idx, then go to SHIFT. When SHIFT returns with idx==INIT_LEN-1, set init_done and go to IDLE.
  - IDLE: if the gain slot is full, load it (priority). Else if the generic slot is full, load it. Else stay.
  - LOAD: 1 cycle. Latch the frame into the shift register, sen_n<=0, sdio<=bit15, bit count=15.
  - SHIFT: per bit, CLK_DIV cycles sclk=0, then CLK_DIV cycles sclk=1, then shift; sdio updates coincident with sclk falling. After bit0's high phase: sclk<=0, go to HOLD.
  - HOLD: CLK_DIV cycles with sen_n=0, then sen_n<=1, go to GAP.
  - GAP: 2*CLK_DIV cycles with sen_n=1, then INIT (idx+1) or IDLE.
- Frame length is (1 + 32*CLK_DIV + CLK_DIV + 2*CLK_DIV) cycles, LOAD through GAP end.
- A slot is cleared at LOAD of its frame. A new request for the same slot arriving in that same cycle wins: the slot stays full with the new value.
- busy = (state != IDLE) | gain slot full | generic slot full.
- rst_n asserted mid-frame: outputs return to reset values immediately (sen_n=1 aborts the device transaction); after release the init table replays from entry 0.

Decomposition:
- Package ad9866_pkg:
  - spi_frame_t (16-bit packed struct rw/len/addr/data)
  - state enum {INIT, IDLE, LOAD, SHIFT, HOLD, GAP}
  - constant CMD_GAIN=6'h0a
  - constant CMD_SPIWR=6'h3b
  - constant REG_RXGAIN=5'h09
  - init table constant array INIT_TABLE[INIT_LEN] of {addr, data}
- One sub-module, ad9866_spi_shift: shifts the 16-bit frame, generates sclk/sdio/sen_n from the CLK_DIV counter, start/done handshake. The top holds slots, arbitration and the init sequencer.

Test Plan:
- Reset release, CLK_DIV=2, INIT_LEN=2 -> exactly 2 frames matching INIT_TABLE bit-for-bit; each frame 1+64+2+4=71 cycles; init_done=1 after the 2nd GAP; busy=0 after that.
- After init, cmd 0x3b data 0x00000A55 -> cmd_ack 1 cycle after rqst; frame 0x0A55 on sdio, sampled on sclk rising edges; sen_n high after.
- cmd 0x0a data 0x45, then 0x0a data 0x20 during the 0x3b frame -> single gain frame with data {01, ~0x20[5:0]} = 0x5F to reg 0x09; the gain frame precedes any pending 0x3b.
- Two 0x3b rqsts during one frame (the 2nd while the slot is full) -> 2nd not acked, ovf=1, only the 1st executed.
- Gain and generic both pending at frame end -> gain frame first, generic next; each slot cleared at its own LOAD.
- rst_n low at bit 7 of a frame -> sen_n=1, sclk=0 asynchronously; after release, init replays from entry 0 and init_done=0 until it completes.
